// File: rtl/log2_approx_if.sv
// Handshake bundle for the multi-lane log2 approximator: input beat side and
// result side, each with its own valid/ready pair.
interface log2_approx_if #(
    parameter int W      = 16,
    parameter int LANES  = 2,
    parameter int SIDE_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic [SIDE_W-1:0]    in_side;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_log;
    logic [LANES*W-1:0]   out_bypass;
    logic [SIDE_W-1:0]    out_side;
    logic [LANES-1:0]     out_sat;

    modport master (
        output in_valid, in_data, in_side, out_ready,
        input  in_ready, out_valid, out_log, out_bypass, out_side, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_side, out_ready,
        output in_ready, out_valid, out_log, out_bypass, out_side, out_sat
    );
endinterface

// File: rtl/log2_approx_pipe.sv
// Two-stage elastic Mitchell log2 approximator: S1 finds the leading one and
// normalised mantissa per lane, S2 combines, saturates and registers results.
module log2_approx_pipe #(
    parameter int W      = 16,
    parameter int FRAC   = 12,
    parameter int LANES  = 2,
    parameter int SIDE_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    log2_approx_if.slave  bus
);
    localparam int PW = $clog2(W);
    // Extra headroom so k*2^FRAC never wraps before the clamp compares.
    localparam int RW = W + 2 + PW;
    localparam logic signed [RW-1:0] R_MIN = RW'(-(longint'(1) <<< (W-1)));
    localparam logic signed [RW-1:0] R_MAX = RW'((longint'(1) <<< (W-1)) - 1);
    localparam logic [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] W_MAX = {1'b0, {(W-1){1'b1}}};

    logic adv;

    logic                 s1_valid_reg;
    logic [LANES*W-1:0]   s1_data_reg;
    logic [SIDE_W-1:0]    s1_side_reg;
    logic [PW-1:0]        s1_p_reg    [LANES];
    logic [FRAC-1:0]      s1_m_reg    [LANES];
    logic                 s1_np_reg   [LANES];

    logic                 s2_valid_reg;
    logic [LANES*W-1:0]   out_log_reg;
    logic [LANES*W-1:0]   out_bypass_reg;
    logic [SIDE_W-1:0]    out_side_reg;
    logic [LANES-1:0]     out_sat_reg;

    logic [PW-1:0]        lane_p_next   [LANES];
    logic [FRAC-1:0]      lane_m_next   [LANES];
    logic                 lane_np_next  [LANES];
    logic [W-1:0]         lane_log_next [LANES];
    logic                 lane_sat_next [LANES];

    assign adv          = en & (~s2_valid_reg | bus.out_ready);
    assign bus.in_ready = adv;

    assign bus.out_valid  = s2_valid_reg;
    assign bus.out_log    = out_log_reg;
    assign bus.out_bypass = out_bypass_reg;
    assign bus.out_side   = out_side_reg;
    assign bus.out_sat    = out_sat_reg;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [W-1:0]            x;
            logic [PW-1:0]           p_c;
            logic [W-1:0]            norm_c;
            logic signed [RW-1:0]    k_c;
            logic signed [RW-1:0]    r_c;
            logic                    under_c;
            logic                    over_c;

            assign x = bus.in_data[gi*W +: W];

            always_comb begin
                p_c = '0;
                for (int b = 0; b <= W-2; b++) begin
                    if (x[b]) begin
                        p_c = PW'(b);
                    end
                end
            end

            // Shift the leading one up to bit W-1; the FRAC bits under it are m.
            assign norm_c           = x << (PW'(W-1) - p_c);
            assign lane_p_next[gi]  = p_c;
            assign lane_m_next[gi]  = FRAC'(norm_c >> (W-1-FRAC));
            assign lane_np_next[gi] = x[W-1] | ~|x;

            assign k_c = $signed({{(RW-PW){1'b0}}, s1_p_reg[gi]}) - RW'(FRAC);
            assign r_c = (k_c <<< FRAC) + $signed({{(RW-FRAC){1'b0}}, s1_m_reg[gi]});

            assign under_c = (r_c < R_MIN);
            assign over_c  = (r_c > R_MAX);

            assign lane_log_next[gi] = (s1_np_reg[gi] | under_c) ? W_MIN :
                                       over_c                    ? W_MAX : r_c[W-1:0];
            assign lane_sat_next[gi] = s1_np_reg[gi] | under_c | over_c;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg   <= 1'b0;
            s1_data_reg    <= '0;
            s1_side_reg    <= '0;
            s2_valid_reg   <= 1'b0;
            out_log_reg    <= '0;
            out_bypass_reg <= '0;
            out_side_reg   <= '0;
            out_sat_reg    <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_p_reg[i]  <= '0;
                s1_m_reg[i]  <= '0;
                s1_np_reg[i] <= 1'b0;
            end
        end else if (adv) begin
            s1_valid_reg   <= bus.in_valid;
            s1_data_reg    <= bus.in_data;
            s1_side_reg    <= bus.in_side;
            s2_valid_reg   <= s1_valid_reg;
            out_bypass_reg <= s1_data_reg;
            out_side_reg   <= s1_side_reg;
            for (int i = 0; i < LANES; i++) begin
                s1_p_reg[i]          <= lane_p_next[i];
                s1_m_reg[i]          <= lane_m_next[i];
                s1_np_reg[i]         <= lane_np_next[i];
                out_log_reg[i*W +: W] <= lane_log_next[i];
                out_sat_reg[i]       <= lane_sat_next[i];
            end
        end
    end
endmodule

// File: tb/tb_log2_approx_pipe.sv
// Randomised and directed bench for log2_approx_pipe, scored against an
// arithmetic log2 model and a queue of accepted beats.
module tb_log2_approx_pipe;
    localparam int W = 16, FRAC = 12, LANES = 2, SIDE_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    always #5 clk = ~clk;

    log2_approx_if #(.W(W), .LANES(LANES), .SIDE_W(SIDE_W)) bus ();

    log2_approx_pipe #(.W(W), .FRAC(FRAC), .LANES(LANES), .SIDE_W(SIDE_W)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Returns {sat, log} from the real-number definition of Mitchell's log2.
    function automatic logic [16:0] model(input logic [15:0] xin);
        longint x, p, m, r;
        x = longint'($signed(xin));
        if (x <= 0) return {1'b1, 16'h8000};
        p = 0;
        while ((longint'(1) << (p + 1)) <= x) p++;
        m = ((x - (longint'(1) << p)) * 4096) / (longint'(1) << p);
        r = (p - FRAC) * 4096 + m;
        if (r < -32768) return {1'b1, 16'h8000};
        if (r > 32767)  return {1'b1, 16'h7FFF};
        return {1'b0, 16'(r)};
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [15:0] side;
        logic [31:0] lg;
        logic [1:0]  sat;
        int          acc;
        bit          strict;
    } exp_t;

    exp_t q[$];
    int   ncyc = 0;
    int   n_pop = 0;
    bit   strict_lat = 1'b0;
    bit   prev_rst = 1'b0;
    bit   held = 1'b0;
    logic [31:0] held_log, held_byp, last_log;
    logic [15:0] held_side;
    logic [1:0]  held_sat, last_sat;

    always @(negedge clk) begin
        exp_t e;
        logic [16:0] r0, r1;
        ncyc++;
        if (prev_rst) chk("rst_clears_out_valid", 64'(bus.out_valid), 64'd0);
        if (rst) begin
            q.delete();
            held = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(bus.in_ready), 64'(en & (~bus.out_valid | bus.out_ready)));
            if (held) begin
                chk("held_valid", 64'(bus.out_valid), 64'd1);
                chk("held_log", 64'(bus.out_log), 64'(held_log));
                chk("held_bypass", 64'(bus.out_bypass), 64'(held_byp));
                chk("held_side", 64'(bus.out_side), 64'(held_side));
                chk("held_sat", 64'(bus.out_sat), 64'(held_sat));
            end
            if (bus.out_valid & bus.out_ready & en) begin
                n_pop++;
                if (q.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_log", 64'(bus.out_log), 64'(e.lg));
                    chk("out_sat", 64'(bus.out_sat), 64'(e.sat));
                    chk("out_bypass", 64'(bus.out_bypass), 64'(e.data));
                    chk("out_side", 64'(bus.out_side), 64'(e.side));
                    if (e.strict) chk("latency", 64'(ncyc - e.acc), 64'd2);
                    last_log = bus.out_log;
                    last_sat = bus.out_sat;
                end
            end
            if (bus.in_valid & bus.in_ready) begin
                r0 = model(bus.in_data[15:0]);
                r1 = model(bus.in_data[31:16]);
                e.data   = bus.in_data;
                e.side   = bus.in_side;
                e.lg     = {r1[15:0], r0[15:0]};
                e.sat    = {r1[16], r0[16]};
                e.acc    = ncyc;
                e.strict = strict_lat;
                q.push_back(e);
            end
            held      = bus.out_valid & ~(bus.out_ready & en);
            held_log  = bus.out_log;
            held_byp  = bus.out_bypass;
            held_side = bus.out_side;
            held_sat  = bus.out_sat;
        end
        prev_rst = rst;
    end

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns #1 after the edge that accepted it.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s);
        bit acc;
        int budget;
        bus.in_valid = 1'b1;
        bus.in_data  = {b, a};
        bus.in_side  = s;
        acc = 1'b0;
        budget = 0;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready & ~rst;
            @(posedge clk);
            #1;
            budget++;
            if (!acc && budget > 100) begin
                chk("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
    endtask

    function automatic logic [15:0] rnd_x();
        case ($urandom_range(0, 3))
            0:       return 16'($urandom);
            1:       return 16'($urandom_range(1, 255));
            2:       return 16'(1 << $urandom_range(0, 14));
            default: return 16'($urandom_range(0, 1) ? 0 : 16'hF000 | 16'($urandom_range(0, 4095)));
        endcase
    endfunction

    int pop_base;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_side   = '0;
        bus.out_ready = 1'b1;

        chk("model_0040", 64'(model(16'h0040)), 64'h0A000);
        chk("model_00C0", 64'(model(16'h00C0)), 64'h0B800);
        chk("model_7FFF", 64'(model(16'h7FFF)), 64'h02FFF);
        chk("model_0010", 64'(model(16'h0010)), 64'h08000);
        chk("model_0008", 64'(model(16'h0008)), 64'h18000);
        chk("model_F000", 64'(model(16'hF000)), 64'h18000);

        @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_log", 64'(bus.out_log), 64'd0);
        chk("reset_out_bypass", 64'(bus.out_bypass), 64'd0);
        chk("reset_out_side", 64'(bus.out_side), 64'd0);
        chk("reset_out_sat", 64'(bus.out_sat), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        strict_lat = 1'b1;
        send(16'h0040, 16'h00C0, 16'hBEEF);
        idle(4);
        chk("single_beat_log", 64'(last_log), 64'hB800A000);
        chk("single_beat_sat", 64'(last_sat), 64'd0);

        send(16'h1000, 16'h0001, 16'h0001);
        send(16'h2000, 16'h0002, 16'h0002);
        send(16'h3000, 16'h0003, 16'h0003);
        send(16'h7FFF, 16'h0004, 16'h0004);
        idle(4);
        chk("sweep_last_log_lane0", 64'(last_log[15:0]), 64'h2FFF);
        strict_lat = 1'b0;

        send(16'h0010, 16'h0008, 16'h0010);
        idle(3);
        chk("boundary_sat_1", 64'(last_sat), 64'b10);
        send(16'h0000, 16'hF000, 16'h0011);
        idle(4);
        chk("boundary_sat_2", 64'(last_sat), 64'b11);

        pop_base = n_pop;
        fork
            begin
                for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i), 16'h0200 * 16'(i + 1), 16'(i));
                bus.in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        idle(6);
        chk("backpressure_count", 64'(n_pop - pop_base), 64'd4);

        send(16'h0123, 16'h4567, 16'hAAAA);
        send(16'h0FFF, 16'h0001, 16'hBBBB);
        bus.in_valid = 1'b0;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1 en = 1'b1;
        idle(4);

        send(16'h0321, 16'h0654, 16'hCCCC);
        send(16'h0777, 16'h0888, 16'hDDDD);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(6);

        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = {rnd_x(), rnd_x()};
            bus.in_side   = 16'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            en            = ($urandom_range(0, 9) != 0);
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        bus.out_ready = 1'b1;
        idle(8);
        chk("drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
